// File: rtl/motor_step_gen_pkg.sv
// Shared types and helpers for the motor step generator.
package motor_step_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, CALC, SETUP, RUN, FIN} state_t;

  localparam int unsigned POS_MAX   = 999;
  localparam int unsigned BCD_MAX   = 9;
  localparam int unsigned SEL_MAX_W = 16;

  // True when exactly one select bit is set.
  function automatic logic is_onehot(input logic [SEL_MAX_W-1:0] sel);
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction

  // Index of the set bit; only meaningful when is_onehot(sel) holds.
  function automatic logic [3:0] onehot_to_idx(input logic [SEL_MAX_W-1:0] sel);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < SEL_MAX_W; i++) begin
      if (sel[i]) idx = i[3:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/motor_step_gen_step_pulse_timer.sv
// Step pulse timer: while en is high, repeats periods of `period` cycles with
// the pulse high for the first `high_w` cycles. fall marks the last high
// cycle, eop the last cycle of the period.
module step_pulse_timer (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] period,
  input  logic [31:0] high_w,
  output logic        pulse,
  output logic        fall,
  output logic        eop
);

  logic [31:0] cnt;

  // Period counter, restarts whenever the timer is disabled.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst)              cnt <= '0;
    else if (!en || eop)   cnt <= '0;
    else                   cnt <= cnt + 32'd1;
  end

  // Pulse shaping and period markers.
  always_comb begin
    pulse = en && (cnt < high_w);
    fall  = en && (cnt == high_w - 32'd1);
    eop   = en && (cnt == period - 32'd1);
  end

endmodule

// File: rtl/motor_step_gen.sv
// Stepper move sequencer: on a start edge moves the selected motor from its
// stored position to the BCD target with step/dir pulses.
// Optional linear accel/decel ramp: define MOTOR_STEP_GEN_ACCEL_EN.
module motor_step_gen
  import motor_step_pkg::*;
#(
  parameter int NUM_MOT     = 6,
  parameter int POS_W       = 10,
  parameter int STEP_PERIOD = 50000,
  parameter int PULSE_W     = 100,
  parameter int DIR_SETUP   = 20
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         t_hund,
  input  logic [3:0]         t_tens,
  input  logic [3:0]         t_ones,
  input  logic [NUM_MOT-1:0] mot_sel,
  output logic [NUM_MOT-1:0] step,
  output logic [NUM_MOT-1:0] dir,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [POS_W-1:0]   cur_pos
);

  localparam int IDX_W = (NUM_MOT > 1) ? $clog2(NUM_MOT) : 1;
  localparam logic [POS_W-1:0] ONE = POS_W'(1);

  state_t               state, nstate;
  logic                 start_q, start_re;
  logic [3:0]           h_q, t_q, o_q;
  logic [NUM_MOT-1:0]   sel_q;
  logic [POS_W-1:0]     pos [NUM_MOT];
  logic [POS_W-1:0]     remaining, tgt, hx, tx, ox;
  logic [IDX_W-1:0]     idx, cur_idx;
  logic [31:0]          setup_cnt, per;
  logic [SEL_MAX_W-1:0] sel_live_ext, sel_q_ext;
  logic                 req_ok;
  logic                 t_pulse, t_fall, t_eop;

  assign start_re = start & ~start_q;

  // Request decode: validity of live inputs, target and index from latched ones.
  always_comb begin
    sel_live_ext = '0;
    sel_live_ext[NUM_MOT-1:0] = mot_sel;
    sel_q_ext = '0;
    sel_q_ext[NUM_MOT-1:0] = sel_q;
    req_ok = is_onehot(sel_live_ext) && (t_hund <= 4'(BCD_MAX)) &&
             (t_tens <= 4'(BCD_MAX)) && (t_ones <= 4'(BCD_MAX));
    idx = IDX_W'(onehot_to_idx(sel_q_ext));
    hx  = POS_W'(h_q);
    tx  = POS_W'(t_q);
    ox  = POS_W'(o_q);
    tgt = (hx << 6) + (hx << 5) + (hx << 2) + (tx << 3) + (tx << 1) + ox;
    cur_pos = pos[cur_idx];
  end

  // FSM state register.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  // Next state and status/step outputs.
  always_comb begin
    nstate = state;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    step   = '0;
    unique case (state)
      IDLE:  if (start_re) nstate = LOAD;
      LOAD: begin
        busy = 1'b1;
        if (req_ok) nstate = CALC;
        else begin
          err    = 1'b1;
          nstate = IDLE;
        end
      end
      CALC: begin
        busy   = 1'b1;
        nstate = (tgt == pos[idx]) ? FIN : SETUP;
      end
      SETUP: begin
        busy = 1'b1;
        if (setup_cnt == 32'(DIR_SETUP - 1)) nstate = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        step[idx] = t_pulse;
        if (t_fall && (remaining == ONE)) nstate = FIN;
      end
      FIN: begin
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Datapath: request latch, direction, positions and counters.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      start_q   <= 1'b0;
      h_q       <= '0;
      t_q       <= '0;
      o_q       <= '0;
      sel_q     <= '0;
      dir       <= '0;
      remaining <= '0;
      cur_idx   <= '0;
      setup_cnt <= '0;
      for (int unsigned i = 0; i < NUM_MOT; i++) pos[i] <= '0;
    end else begin
      start_q <= start;
      unique case (state)
        LOAD: begin
          h_q   <= t_hund;
          t_q   <= t_tens;
          o_q   <= t_ones;
          sel_q <= mot_sel;
        end
        CALC: begin
          cur_idx   <= idx;
          setup_cnt <= '0;
          if (tgt != pos[idx]) begin
            dir[idx]  <= (tgt > pos[idx]);
            remaining <= (tgt > pos[idx]) ? (tgt - pos[idx]) : (pos[idx] - tgt);
          end
        end
        SETUP: setup_cnt <= setup_cnt + 32'd1;
        RUN: begin
          if (t_fall) begin
            pos[idx]  <= dir[idx] ? (pos[idx] + ONE) : (pos[idx] - ONE);
            remaining <= remaining - ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MOTOR_STEP_GEN_ACCEL_EN
  localparam logic [31:0] P_CR  = 32'(STEP_PERIOD);
  localparam logic [31:0] P_MAX = 32'(4 * STEP_PERIOD);
  localparam logic [31:0] P_Q   = 32'(STEP_PERIOD / 4);
  logic [31:0] ramp_k;

  // Ramp: period adjusts at each period end; decelerate once the remaining
  // steps no longer exceed the ramp steps taken, giving a mirrored profile.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      per    <= P_MAX;
      ramp_k <= '0;
    end else if (state == CALC) begin
      per    <= P_MAX;
      ramp_k <= '0;
    end else if (state == RUN && t_eop) begin
      if ((32'(remaining) <= ramp_k) && (ramp_k != '0)) begin
        per    <= per + P_Q;
        ramp_k <= ramp_k - 32'd1;
      end else if (per > P_CR) begin
        per    <= ((per - P_Q) < P_CR) ? P_CR : (per - P_Q);
        ramp_k <= ramp_k + 32'd1;
      end
    end
  end
`else
  logic eop_unused;
  assign per        = 32'(STEP_PERIOD);
  assign eop_unused = t_eop;
`endif

  step_pulse_timer u_timer (
    .sysclk (sysclk),
    .rst    (rst),
    .en     (state == RUN),
    .period (per),
    .high_w (32'(PULSE_W)),
    .pulse  (t_pulse),
    .fall   (t_fall),
    .eop    (t_eop)
  );

endmodule

// File: tb/tb_motor_step_gen.sv
// Directed bench for motor_step_gen (STEP_PERIOD=8, PULSE_W=2, DIR_SETUP=3).
module tb_motor_step_gen;

  logic       sysclk;
  logic       rst;
  logic       start;
  logic [3:0] t_hund, t_tens, t_ones;
  logic [5:0] mot_sel;
  logic [5:0] step, dir;
  logic       busy, done, err;
  logic [9:0] cur_pos;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  int unsigned cyc = 0;
  int unsigned pulses [6];
  int unsigned done_cnt = 0, err_cnt = 0, busy_cyc = 0, stray = 0;
  int unsigned dir_chg_cyc = 0;
  int unsigned rise_q [$];
  logic [5:0]  step_prev = '0, dir_prev = '0, exp_sel = '0;

  motor_step_gen #(
    .NUM_MOT(6), .POS_W(10), .STEP_PERIOD(8), .PULSE_W(2), .DIR_SETUP(3)
  ) dut (
    .sysclk(sysclk), .rst(rst), .start(start),
    .t_hund(t_hund), .t_tens(t_tens), .t_ones(t_ones), .mot_sel(mot_sel),
    .step(step), .dir(dir), .busy(busy), .done(done), .err(err), .cur_pos(cur_pos)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Observation on the falling edge: pulse counts, status pulses, stray steps.
  always @(negedge sysclk) begin
    cyc++;
    for (int i = 0; i < 6; i++) begin
      if (step[i] && !step_prev[i]) begin
        pulses[i]++;
        rise_q.push_back(cyc);
      end
    end
    if ((step & ~exp_sel) != '0) stray++;
    if (dir != dir_prev) dir_chg_cyc = cyc;
    if (done) done_cnt++;
    if (err)  err_cnt++;
    if (busy) busy_cyc++;
    step_prev = step;
    dir_prev  = dir;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned psum();
    int unsigned s = 0;
    for (int i = 0; i < 6; i++) s += pulses[i];
    return s;
  endfunction

  // Wait (bounded) until a done or err pulse has been seen since the snapshot.
  task automatic wait_end(input int unsigned d0, input int unsigned e0);
    bit seen = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge sysclk);
      if (done_cnt != d0 || err_cnt != e0) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("timeout", 0, 1);
  endtask

  task automatic run_req(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                         input logic [5:0] sel);
    int unsigned d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    t_hund  = h;
    t_tens  = t;
    t_ones  = o;
    mot_sel = sel;
    exp_sel = sel;
    start   = 1'b1;
    wait_end(d0, e0);
    start = 1'b0;
    repeat (3) @(negedge sysclk);
  endtask

  initial begin
    int unsigned p0, d0, e0, b0, n0, s0;
    bit hit;
    for (int i = 0; i < 6; i++) pulses[i] = 0;
    rst = 1'b0; start = 1'b0;
    t_hund = '0; t_tens = '0; t_ones = '0; mot_sel = '0;
    repeat (3) @(negedge sysclk);
    chk("rst_step", 32'(step), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_pos", 32'(cur_pos), 0);
    rst = 1'b1;
    repeat (2) @(negedge sysclk);

    // 0 -> 123 on motor 1
    p0 = pulses[0]; d0 = done_cnt;
    run_req(4'd1, 4'd2, 4'd3, 6'b000001);
    chk("m1_dir_up", 32'(dir[0]), 1);
    chk("m1_pulses", pulses[0] - p0, 123);
    chk("m1_done", done_cnt - d0, 1);
    chk("m1_pos", 32'(cur_pos), 123);

    // 123 -> 20, dir setup time before first step
    p0 = pulses[0]; n0 = rise_q.size();
    run_req(4'd0, 4'd2, 4'd0, 6'b000001);
    chk("m2_dir_dn", 32'(dir[0]), 0);
    chk("m2_pulses", pulses[0] - p0, 103);
    chk("m2_pos", 32'(cur_pos), 20);
    chk("m2_setup_ge3", (rise_q.size() > n0) ? 32'(rise_q[n0] - dir_chg_cyc >= 3) : 0, 1);

    // zero-length move
    p0 = pulses[0]; d0 = done_cnt; b0 = busy_cyc;
    run_req(4'd0, 4'd2, 4'd0, 6'b000001);
    chk("z_pulses", pulses[0] - p0, 0);
    chk("z_done", done_cnt - d0, 1);
    chk("z_busy_cyc", busy_cyc - b0, 2);

    // rejected: two select bits
    s0 = psum(); d0 = done_cnt; e0 = err_cnt;
    run_req(4'd1, 4'd0, 4'd0, 6'b000011);
    chk("e1_err", err_cnt - e0, 1);
    chk("e1_done", done_cnt - d0, 0);
    chk("e1_steps", psum() - s0, 0);
    chk("e1_pos", 32'(cur_pos), 20);

    // rejected: tens digit 0xA
    s0 = psum(); d0 = done_cnt; e0 = err_cnt;
    run_req(4'd0, 4'hA, 4'd0, 6'b000001);
    chk("e2_err", err_cnt - e0, 1);
    chk("e2_done", done_cnt - d0, 0);
    chk("e2_steps", psum() - s0, 0);
    chk("e2_pos", 32'(cur_pos), 20);

    // motor 3: 0 -> 100, first step period
    p0 = pulses[2]; n0 = rise_q.size();
    run_req(4'd1, 4'd0, 4'd0, 6'b000100);
    chk("m3_pulses", pulses[2] - p0, 100);
`ifdef MOTOR_STEP_GEN_ACCEL_EN
    chk("m3_first_period", (rise_q.size() > n0 + 1) ? rise_q[n0+1] - rise_q[n0] : 0, 32);
`else
    chk("m3_first_period", (rise_q.size() > n0 + 1) ? rise_q[n0+1] - rise_q[n0] : 0, 8);
`endif

    // 100 -> 0 with a second start edge mid-move
    p0 = pulses[2]; d0 = done_cnt; e0 = err_cnt;
    t_hund = 4'd0; t_tens = 4'd0; t_ones = 4'd0; mot_sel = 6'b000100;
    start = 1'b1;
    repeat (3) @(negedge sysclk);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge sysclk);
      if (pulses[2] - p0 >= 40) begin
        hit = 1;
        break;
      end
    end
    if (!hit) chk("re_timeout", 0, 1);
    start = 1'b1;
    repeat (5) @(negedge sysclk);
    start = 1'b0;
    wait_end(d0, e0);
    repeat (50) @(negedge sysclk);
    chk("re_pulses", pulses[2] - p0, 100);
    chk("re_done", done_cnt - d0, 1);
    chk("re_pos", 32'(cur_pos), 0);
    chk("re_dir", 32'(dir[2]), 0);

    // a new start after done is accepted
    p0 = pulses[2];
    run_req(4'd0, 4'd0, 4'd5, 6'b000100);
    chk("nx_pulses", pulses[2] - p0, 5);
    chk("nx_pos", 32'(cur_pos), 5);

    // reset during step 50 of 0 -> 200 on motor 2
    p0 = pulses[1];
    t_hund = 4'd2; t_tens = 4'd0; t_ones = 4'd0; mot_sel = 6'b000010; exp_sel = 6'b000010;
    start = 1'b1;
    hit = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge sysclk);
      if (pulses[1] - p0 >= 50) begin
        hit = 1;
        break;
      end
    end
    if (!hit) chk("rm_timeout", 0, 1);
    rst = 1'b0;
    #1;
    chk("rm_step", 32'(step), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_pos", 32'(cur_pos), 0);
    start = 1'b0;
    repeat (4) @(negedge sysclk);
    rst = 1'b1;
    repeat (30) @(negedge sysclk);
    chk("rm_pulses", pulses[1] - p0, 50);
    chk("rm_pos_after", 32'(cur_pos), 0);
    chk("rm_busy_after", 32'(busy), 0);

    chk("stray_steps", stray, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/motor_step_gen.md
Name: motor_step_gen

Overview:
- Downstream stage of the 5-key target-entry block.
- Consumes the committed BCD target position (hundreds/tens/ones) and the one-hot motor select (6 motors). On a start edge, moves the selected stepper from its stored position to the target by emitting step/dir pulses.
- Holds one absolute position register per motor. Reports busy/done/err to the display/status logic.

Parameters:
- NUM_MOT, 6, number of motors; width of the one-hot select and of the step/dir buses.
- POS_W, 10, position register width in bits; holds 0..999.
- STEP_PERIOD, 50000, sysclk cycles per step at cruise; must be ≥ PULSE_W+1.
- PULSE_W, 100, sysclk cycles the step output is held high.
- DIR_SETUP, 20, sysclk cycles dir is stable before the first step rises.

Ports:
- sysclk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level from the Enter key; a move is triggered on its rising edge.
- t_hund  in  4  BCD hundreds digit of the target.
- t_tens  in  4  BCD tens digit of the target.
- t_ones  in  4  BCD ones digit of the target.
- mot_sel  in  NUM_MOT  one-hot motor select; bit0 = motor 1.
- step  out  NUM_MOT  step pulse; only the active motor's bit toggles.
- dir  out  NUM_MOT  direction per motor; 1 = increasing position.
- busy  out  1  high from the LOAD state through the RUN state.
- done  out  1  1-cycle pulse when a move completes, including zero-length moves.
- err  out  1  1-cycle pulse when a request is rejected.
- cur_pos  out  POS_W  position of the last selected motor.

Behaviour:
- Reset (rst=0, async): all position registers = 0, step = 0, dir = 0, busy/done/err = 0, cur_pos = 0, FSM = IDLE. Reset mid-move aborts the move immediately, with no further pulses.
- Start edge detection: start is registered; start_re = start & ~start_q. Edges arriving while busy=1 are ignored, not queued.
- IDLE: on start_re go to LOAD. The upstream latch updates on the same clock as Enter, so inputs are not sampled yet.
- LOAD (1 cycle): sample t_hund, t_tens, t_ones and mot_sel.
  - If mot_sel is not exactly one-hot, or any digit > 9: err=1 for 1 cycle, go to IDLE, no state change.
  - Otherwise go to CALC.
- CALC (1 cycle):
  - tgt = hund*100 + tens*10 + ones, computed in POS_W bits with shifts/adds only (hund*100 = (h<<6)+(h<<5)+(h<<2); tens*10 = (t<<3)+(t<<1)).
  - idx = encoded mot_sel.
  - If tgt == pos[idx]: go to FIN.
  - Otherwise set dir[idx] = (tgt > pos[idx]), remaining = |tgt − pos[idx]|, go to SETUP.
- SETUP: count DIR_SETUP cycles, then go to RUN.
- RUN, per step:
  - step[idx] is high for PULSE_W cycles, then low for STEP_PERIOD−PULSE_W cycles (cruise period; see ACCEL_EN).
  - On the falling edge of step, pos[idx] moves ±1 and remaining decrements.
  - When remaining reaches 0 after a falling edge, go to FIN.
- FIN (1 cycle): done=1, busy=0 next cycle, go to IDLE.
- dir bits hold their last value between moves. Non-active step bits stay 0 at all times.
- cur_pos = pos[idx of last accepted request]; it updates on every position change.
- Positions never leave 0..999: the target is bounded by the BCD check, so no wrap is possible.
- start held high for many cycles produces exactly one move.

Optional Feature:
- Macro: MOTOR_STEP_GEN_ACCEL_EN.
- Defined: linear ramp.
  - The first step period is 4*STEP_PERIOD.
  - Each subsequent step period drops by STEP_PERIOD/4 until it reaches STEP_PERIOD.
  - Deceleration mirrors this: when remaining ≤ ramp steps taken, the period increases symmetrically.
  - Short moves form a triangle profile.
  - The high time stays PULSE_W.
- Undefined: constant STEP_PERIOD for every step; ramp logic and counters are absent.

Decomposition:
- Package motor_step_pkg holds:
  - FSM state enum: IDLE, LOAD, CALC, SETUP, RUN, FIN.
  - POS_MAX = 999.
  - BCD_MAX = 9.
  - Function onehot_to_idx with an is_onehot check.
- One sub-module, step_pulse_timer: given period and high-time, it emits one pulse per enable and flags end-of-period. Both RUN and the ramp use it.

Test Plan (STEP_PERIOD=8, PULSE_W=2, DIR_SETUP=3):
- Reset, then start with 1/2/3 on motor 6'b000001 → dir[0]=1, 123 step pulses on step[0], done, cur_pos=123, other step bits 0.
- Then 0/2/0 on the same motor → dir[0]=0, exactly 103 pulses, cur_pos=20. First rising step ≥3 cycles after dir settles.
- Target equals current position (0/2/0 again) → no pulses, done 1 cycle, busy high for LOAD+CALC only.
- mot_sel=6'b000011, or t_tens=4'hA → err pulse, no steps, positions unchanged, no done.
- Second start edge mid-move (100→0) → ignored. Pulse count stays 100. After done, a new start is accepted.
- rst low during step 50 of a 0→200 move → step=0, busy=0 immediately, cur_pos=0 after reset. With ACCEL_EN, the first period is 32 cycles and the cruise period is 8.
